// File: rtl/updown_tcounter.sv
// updown_tcounter: T-enabled up/down counter with modulus, load, wrap/saturate, Gray output and wrap flags
module updown_tcounter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             T,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             at_end;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] wrapped;

    // terminal detection happens before the add, so an increment never forms MODULUS
    always_comb begin
        at_end  = up ? count == MAX : count == '0;
        step    = up ? count + WIDTH'(1) : count - WIDTH'(1);
        wrapped = sat ? count : (up ? '0 : MAX);
    end

    // priority rst > load > T; tc marks a count produced by a wrap or saturation event
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_val > MAX ? MAX : load_val;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (T) begin
            count <= at_end ? wrapped : step;
            tc    <= at_end;
            ovf   <= ovf | at_end;
        end else begin
            tc    <= 1'b0;
        end
    end

    assign gray = count ^ (count >> 1);
endmodule

// File: tb/tb_updown_tcounter.sv
// tb_updown_tcounter: directed checks plus per-cycle model comparison on a legacy and a modulus-10 instance
module tb_updown_tcounter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, T = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [2:0] count_a, gray_a;
    logic       tc_a, ovf_a;
    logic [3:0] count_b, gray_b;
    logic       tc_b, ovf_b;

    int checks = 0, errors = 0;
    int ma = 0, mb = 0;
    bit ta, tb, oa, ob, valid;

    updown_tcounter u_a (
        .clk(clk), .rst(rst), .T(T), .up(up), .sat(sat), .load(load),
        .load_val(load_val[2:0]), .count(count_a), .gray(gray_a), .tc(tc_a), .ovf(ovf_a)
    );

    updown_tcounter #(.WIDTH(4), .MODULUS(10)) u_b (
        .clk(clk), .rst(rst), .T(T), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count_b), .gray(gray_b), .tc(tc_b), .ovf(ovf_b)
    );

    function automatic bit hit(int c, int m, bit u);
        return u ? c + 1 >= m : c - 1 < 0;
    endfunction

    function automatic int nxt(int c, int m, bit u, bit s);
        int n = u ? c + 1 : c - 1;
        if (n < 0 || n >= m) n = s ? c : (u ? 0 : m - 1);
        return n;
    endfunction

    function automatic int clamp(int v, int m);
        return v >= m ? m - 1 : v;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ma <= 0; mb <= 0; ta <= 0; tb <= 0; oa <= 0; ob <= 0; valid <= 1;
        end else if (load) begin
            ma <= clamp(int'(load_val[2:0]), 8);
            mb <= clamp(int'(load_val), 10);
            ta <= 0; tb <= 0; oa <= 0; ob <= 0;
        end else if (T) begin
            ma <= nxt(ma, 8, up, sat);
            mb <= nxt(mb, 10, up, sat);
            ta <= hit(ma, 8, up);
            tb <= hit(mb, 10, up);
            oa <= oa | hit(ma, 8, up);
            ob <= ob | hit(mb, 10, up);
        end else begin
            ta <= 0; tb <= 0;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model count_a", 32'(count_a), ma);
            check("model gray_a", 32'(gray_a), ma ^ (ma >> 1));
            check("model tc_a", 32'(tc_a), 32'(ta));
            check("model ovf_a", 32'(ovf_a), 32'(oa));
            check("model count_b", 32'(count_b), mb);
            check("model gray_b", 32'(gray_b), mb ^ (mb >> 1));
            check("model tc_b", 32'(tc_b), 32'(tb));
            check("model ovf_b", 32'(ovf_b), 32'(ob));
        end
    end

    task automatic drive(bit r, bit t, bit u, bit s, bit l, int v);
        rst = r; T = t; up = u; sat = s; load = l; load_val = 4'(v);
        @(posedge clk);
        #1;
    endtask

    int leg_cnt [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int leg_gray[10] = '{1, 3, 2, 6, 7, 5, 4, 0, 1, 3};
    int mod_cnt [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

    initial begin
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 1, 3);
        check("reset count_a", 32'(count_a), 0);
        check("reset gray_a", 32'(gray_a), 0);
        check("reset tc_a", 32'(tc_a), 0);
        check("reset ovf_a", 32'(ovf_a), 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            check("legacy count", 32'(count_a), leg_cnt[i]);
            check("legacy gray", 32'(gray_a), leg_gray[i]);
            check("legacy tc", 32'(tc_a), i == 7);
            check("legacy ovf", 32'(ovf_a), i >= 7);
        end
        drive(1, 0, 1, 0, 0, 0);
        check("mod10 reset", 32'(count_b), 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            check("mod10 up count", 32'(count_b), mod_cnt[i]);
            check("mod10 up tc", 32'(tc_b), i == 9);
        end
        drive(0, 1, 0, 0, 0, 0);
        check("mod10 down wrap", 32'(count_b), 9);
        check("mod10 down wrap tc", 32'(tc_b), 1);
        drive(0, 1, 0, 0, 0, 0);
        check("mod10 down", 32'(count_b), 8);
        check("mod10 down tc", 32'(tc_b), 0);
        drive(0, 1, 1, 1, 1, 8);
        check("sat load 8", 32'(count_b), 8);
        check("sat load ovf clr", 32'(ovf_b), 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 1, 0, 0);
            check("sat up count", 32'(count_b), 9);
            check("sat up tc", 32'(tc_b), i > 0);
        end
        drive(0, 0, 1, 1, 1, 1);
        check("sat load 1", 32'(count_b), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0, 0);
            check("sat down count", 32'(count_b), 0);
            check("sat down tc", 32'(tc_b), i > 0);
        end
        check("sat ovf", 32'(ovf_b), 1);
        drive(0, 0, 1, 0, 1, 5);
        check("load 5", 32'(count_b), 5);
        check("load 5 ovf", 32'(ovf_b), 0);
        drive(0, 0, 1, 0, 1, 12);
        check("load clamp", 32'(count_b), 9);
        check("load 12 narrow", 32'(count_a), 4);
        drive(0, 1, 1, 0, 1, 3);
        check("load beats wrap", 32'(count_b), 3);
        check("load beats wrap tc", 32'(tc_b), 0);
        check("load beats wrap ovf", 32'(ovf_b), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            check("hold", 32'(count_b), 3);
        end
        drive(0, 1, 1, 0, 0, 0);
        check("flip up", 32'(count_b), 4);
        drive(0, 1, 0, 0, 0, 0);
        check("flip down", 32'(count_b), 3);
        drive(0, 1, 1, 0, 0, 0);
        check("flip up again", 32'(count_b), 4);
        drive(0, 0, 1, 0, 1, 1);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("pre-reset count", 32'(count_b), 6);
        check("pre-reset ovf", 32'(ovf_b), 1);
        drive(1, 1, 1, 0, 1, 2);
        check("rst priority count", 32'(count_b), 0);
        check("rst priority tc", 32'(tc_b), 0);
        check("rst priority ovf", 32'(ovf_b), 0);
        drive(0, 1, 1, 0, 0, 0);
        check("rst release", 32'(count_b), 1);
        drive(0, 0, 1, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/updown_tcounter.md
# updown_tcounter

Parametrised successor to the team's fixed 3-bit toggle counter. A T-enabled counter of `WIDTH` bits with a programmable modulus, up/down direction, parallel load, wrap-or-saturate mode, Gray-coded output and wrap/overflow flags. It is used wherever the design needs a cycle or event counter. With defaults and `up=1`, `sat=0`, `load=0`, it behaves as the old 3-bit counter: it counts 0..7 and wraps while `T=1`.

## Interface
- `WIDTH`, default 3: counter width in bits; must be at least 1.
- `MODULUS`, default 8: count range is 0..MODULUS-1; requires 2 ≤ MODULUS ≤ 2^WIDTH.
- `clk` in, 1 bit: single clock; all state updates on the rising edge.
- `rst` in, 1 bit: reset, synchronous and active-high.
- `T` in, 1 bit: count enable; the counter steps one position per clock while high.
- `up` in, 1 bit: direction; 1 = increment, 0 = decrement.
- `sat` in, 1 bit: boundary mode; 1 = saturate at the limit, 0 = wrap.
- `load` in, 1 bit: parallel load strobe.
- `load_val` in, WIDTH bits: value captured when `load`=1.
- `count` out, WIDTH bits: registered binary count.
- `gray` out, WIDTH bits: Gray code of `count`, defined as `count ^ (count >> 1)`; combinational from the `count` register.
- `tc` out, 1 bit: registered flag; high for the one cycle in which `count` holds a value produced by a wrap or saturation event.
- `ovf` out, 1 bit: sticky registered flag; set by any wrap or saturation event.

## Operation
- Priority on each rising edge: `rst` > `load` > `T`. Inputs are sampled only at the edge.
- **rst=1:**
  - `count`=0, `tc`=0, `ovf`=0.
  - `gray` therefore reads 0.
  - `rst` overrides `load` and `T` in the same cycle.
- **load=1 (rst=0):**
  - `count` ← `load_val` if `load_val` < MODULUS, else MODULUS-1 (clamp).
  - `tc` ← 0 and `ovf` ← 0.
  - `T` is ignored in this cycle.
- **T=1 (rst=0, load=0), up=1:**
  - If `count` < MODULUS-1: `count`+1, `tc` ← 0.
  - If `count` = MODULUS-1 and sat=0: `count` ← 0, `tc` ← 1, `ovf` ← 1.
  - If `count` = MODULUS-1 and sat=1: `count` holds, `tc` ← 1, `ovf` ← 1.
- **T=1 (rst=0, load=0), up=0:**
  - If `count` > 0: `count`-1, `tc` ← 0.
  - If `count` = 0 and sat=0: `count` ← MODULUS-1, `tc` ← 1, `ovf` ← 1.
  - If `count` = 0 and sat=1: `count` holds at 0, `tc` ← 1, `ovf` ← 1.
- **T=0 (rst=0, load=0):** `count` and `ovf` hold; `tc` ← 0.
- **Mode changes:** `up` and `sat` may change on any cycle and take effect on the same edge; no pipeline, no glitch state.
- **Arithmetic:**
  - Comparisons are unsigned, at WIDTH bits.
  - An increment never forms MODULUS, because the terminal check happens before the add.
  - When MODULUS = 2^WIDTH, the wrap coincides with natural binary overflow.
- **Gray output:** adjacent codes differ in exactly one bit, including across the wrap, only when MODULUS is a power of two. For other moduli the wrap transition may change several bits; this is accepted and documented.
- **Saturated hold:** while saturated and `T`=1, `tc` stays high on every cycle that the event repeats (one event per enabled cycle).

## Timing
- Latency from an enabled edge to `count`, `tc` and `ovf`: 1 clock. `gray` follows `count` in the same cycle, through combinational logic only.
- No handshake; `T` may be held high indefinitely, giving one step per clock. Maximum rate is one step per cycle.
- Reset mid-count: the counter reads 0 on the edge where `rst` is sampled high. Counting resumes on the first edge with `rst`=0 and `T`=1, so that edge gives `count`=1 when up.
- `load` and a terminal condition in the same cycle: load wins; `tc`=0 and `ovf` is cleared.
- All outputs are defined only after the first reset edge. There is no power-on initial value requirement beyond simulation convenience.

## Test plan
- **Legacy equivalence:** defaults, `rst` for 2 cycles, then `T`=1, `up`=1, `sat`=0 for 10 clocks → `count` 1..7, 0, 1, 2; `tc`=1 only in the cycle showing 0; `ovf`=1 from then on; `gray` sequence 1, 3, 2, 6, 7, 5, 4, 0.
- **Non-power-of-2 modulus:** WIDTH=4, MODULUS=10, up → `count` 0..9, 0; down from 0 → 9, 8; `tc` pulses on each wrap.
- **Saturate:** WIDTH=4, MODULUS=10, `sat`=1.
  - Up from 8 for 4 clocks → `count` 9, 9, 9, 9; `tc` 0, 1, 1, 1.
  - Down from 1 for 3 clocks → `count` 0, 0, 0; `tc` 0, 1, 1.
- **Load:**
  - `load_val`=5 → `count`=5, `ovf` cleared.
  - `load_val`=12 with MODULUS=10 → `count`=9.
  - `load`=1 with `T`=1 at the terminal value → no wrap, `tc`=0.
- **Hold and direction flip:** from `count`=3, `T`=0 for 3 clocks → 3, 3, 3. Then `T`=1 with `up` toggling 1, 0, 1 → 4, 3, 4.
- **Reset priority:** at `count`=6, assert `rst` together with `load`=1 (`load_val`=2) and `T`=1 → `count`=0, `tc`=0, `ovf`=0. On release with `T`=1 → `count`=1.
